sirv_gnrl_rr_wr_arb: RTL
========================

// Module: sirv_gnrl_rr_wr_arb
// PURPOSE
//  Round-robin write arbiter and sequencer for one shared DW-bit load-enabled
//  register. NREQ requesters offer data with a valid/ready handshake; at most
//  one write is granted per cycle. The arbiter drives the register load enable
//  and next-data, and tracks the writer ID and a write count. Used where several
//  pipeline agents update one CSR/config/status register.
// PARAMETERS
//  DW    32  width of the shared register and of each request data word
//  NREQ  4   number of requesters (>=1)
//  IW    2   requester-ID width = clog2(NREQ), min 1
//  CW    8   width of the write counter
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        async reset, active low
//  req_valid  in   NREQ     bit i: requester i presents a write
//  req_dat    in   NREQ*DW  requester i data in bits [i*DW +: DW]
//  req_ready  out  NREQ     bit i: requester i's write is accepted this cycle
//  wr_stall   in   1        1 = block all grants this cycle
//  qout       out  DW       current shared register value
//  upd_vld    out  1        1-cycle pulse: qout changed on the last edge
//  upd_id     out  IW       ID of the most recent writer
//  upd_cnt    out  CW       count of accepted writes, wraps at 2^CW
// BEHAVIOUR
//  - Clock: clk only. Reset: rst_n async, active low; all flops clear on it.
//  - Reset values: qout=0, upd_vld=0, upd_id=0, upd_cnt=0, rr pointer ptr=0.
//  - Grant (combinational): scan i = ptr, ptr+1, ... mod NREQ. The first i with
//    req_valid[i]=1 gets the grant. req_ready = onehot(grant) & ~wr_stall.
//    req_ready never asserts without the matching req_valid. At most 1 bit is set.
//  - Handshake: a write is accepted when req_valid[i] & req_ready[i] both = 1.
//    Requesters hold valid/data until accepted. Dropping valid early is legal.
//    No combinational path from req_ready back into the grant decision.
//  - Register: the load enable is any(req_ready). On acceptance of i at edge T,
//    qout = req_dat[i] from edge T on. Latency is 1 cycle, with no bubble:
//    back-to-back writes every cycle are legal.
//  - Side outputs at the same edge T: upd_vld=1, upd_id=i, upd_cnt=upd_cnt+1
//    (mod 2^CW).
//  - Idle cycles (no acceptance): qout, upd_id, upd_cnt hold; upd_vld=0.
//  - Pointer: on acceptance of i, ptr becomes (i+1) mod NREQ, with the wrap from
//    NREQ-1 to 0. With no acceptance (no valid, or wr_stall=1), ptr holds.
//  - Fairness: a continuously-valid requester is granted within NREQ acceptances.
//  - wr_stall=1: no ready, no load, no ptr/counter change. Takes effect in the
//    same cycle.
//  - NREQ=1: ready = valid & ~wr_stall. ptr is constant 0.
//  - Reset mid-operation: all state clears immediately. After release, ptr=0, so
//    requester 0 has first priority.
//  - X-check: the load enable must be non-X whenever rst_n=1 (simulation-only
//    checker, excluded in FPGA builds).
// TESTING
//  1. Reset: hold rst_n=0 with random inputs -> qout=0, upd_*=0, req_ready=0.
//     Release -> ptr=0.
//  2. Single: valid=4'b0100, dat2=32'hA5A5_0001 -> ready=4'b0100.
//     Next cycle: qout=A5A50001, upd_vld=1, upd_id=2, upd_cnt=1.
//  3. Round robin: valid=4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3.
//     upd_cnt=8. qout follows each granted data word.
//  4. Stall: valid=4'b0011, wr_stall=1 for 3 cycles -> ready=0, qout and ptr
//     unchanged. Drop stall -> requester 0 granted first, then requester 1.
//  5. Skip/wrap: ptr=3, valid=4'b0010 -> grant 1, ptr becomes 2.
//     Then valid=4'b1001 -> grant 3, ptr wraps to 0.
//  6. Counter wrap and reset: drive 256 writes with CW=8 -> upd_cnt=0.
//     Assert rst_n mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sirv_gnrl_rr_wr_arb.sv
// Round-robin write arbiter for one shared load-enabled register: grants at most
// one requester per cycle and tracks the last writer ID and an accepted-write count.
module sirv_gnrl_rr_wr_arb #(
  parameter int DW   = 32,
  parameter int NREQ = 4,
  parameter int IW   = 2,
  parameter int CW   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_dat,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wr_stall,
  output logic [DW-1:0]      qout,
  output logic               upd_vld,
  output logic [IW-1:0]      upd_id,
  output logic [CW-1:0]      upd_cnt
);

  localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   qout_q, qout_d;
  logic            upd_vld_q, upd_vld_d;
  logic [IW-1:0]   upd_id_q, upd_id_d;
  logic [CW-1:0]   upd_cnt_q, upd_cnt_d;

  logic            gnt_found_s;
  logic [IW-1:0]   gnt_idx_s;
  logic [NREQ-1:0] gnt_oh_s;
  logic [NREQ-1:0] req_ready_s;
  logic            load_en_s;
  logic [DW-1:0]   wr_dat_s;

  // Rotating priority scan starting at the pointer; depends only on valid and ptr.
  always_comb begin
    logic [IW:0] scan_idx;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_idx >= NREQ_W) begin
        scan_idx = scan_idx - NREQ_W;
      end else begin
        scan_idx = scan_idx;
      end
      if (!gnt_found_s && req_valid[scan_idx[IW-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = scan_idx[IW-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // One-hot grant, stall/reset gating and AND-OR data select.
  always_comb begin
    gnt_oh_s = '0;
    wr_dat_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh_s[i] = gnt_found_s && (gnt_idx_s == IW'(i));
      wr_dat_s    = wr_dat_s | ({DW{gnt_oh_s[i]}} & req_dat[i*DW +: DW]);
    end
    req_ready_s = gnt_oh_s & {NREQ{~wr_stall & rst_n}};
    load_en_s   = |req_ready_s;
  end

  // Next-state for the shared register, side outputs and round-robin pointer.
  always_comb begin
    ptr_d     = ptr_q;
    qout_d    = qout_q;
    upd_vld_d = 1'b0;
    upd_id_d  = upd_id_q;
    upd_cnt_d = upd_cnt_q;
    if (load_en_s) begin
      qout_d    = wr_dat_s;
      upd_vld_d = 1'b1;
      upd_id_d  = gnt_idx_s;
      upd_cnt_d = upd_cnt_q + CW'(1);
      ptr_d     = (gnt_idx_s == LAST_ID) ? '0 : gnt_idx_s + IW'(1);
    end else begin
      upd_vld_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      qout_q    <= '0;
      upd_vld_q <= 1'b0;
      upd_id_q  <= '0;
      upd_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      qout_q    <= qout_d;
      upd_vld_q <= upd_vld_d;
      upd_id_q  <= upd_id_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  assign req_ready = req_ready_s;
  assign qout      = qout_q;
  assign upd_vld   = upd_vld_q;
  assign upd_id    = upd_id_q;
  assign upd_cnt   = upd_cnt_q;

`ifndef SYNTHESIS
  sirv_gnrl_rr_wr_arb_chk #(.NREQ(NREQ)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en_s),
    .req_valid (req_valid),
    .req_ready (req_ready_s)
  );
`endif

endmodule

// Simulation-only checker: load enable never X out of reset, grant is legal.
module sirv_gnrl_rr_wr_arb_chk #(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst_n,
  input logic            load_en,
  input logic [NREQ-1:0] req_valid,
  input logic [NREQ-1:0] req_ready
);

  a_load_en_known: assert property (@(posedge clk) rst_n |-> !$isunknown(load_en));
  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_ready_valid:   assert property (@(posedge clk) disable iff (!rst_n)
                                    (req_ready & ~req_valid) == '0);

endmodule
